// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: assembles a big-endian byte stream into 32-bit words,
// writes them from word 0, then releases the core. Trailer checksum built with IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [ADDR_W:0]   len_words_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_data_i,
  output logic              byte_ready_o,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              core_run_o
);

  localparam logic [ADDR_W:0] MAX_LEN  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] WCNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LOAD, WRITE, CHECK, RUN} state_t;
`else
  typedef enum logic [2:0] {IDLE, LOAD, WRITE, RUN} state_t;
`endif

  function automatic logic [ADDR_W:0] clamp_len(input logic [ADDR_W:0] len);
    return (len > MAX_LEN) ? MAX_LEN : len;
  endfunction

  state_t            state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   wcnt_q, wcnt_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [31:0]       shift_q, shift_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              ready_q, ready_d;
  logic              we_q, we_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              run_q, run_d;
  logic              hs;
  logic [31:0]       shifted;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
  logic [7:0]        csum_sum;
  logic              err_q, err_d;
`endif

  assign hs      = byte_valid_i && ready_q;
  assign shifted = {shift_q[23:0], byte_data_i};
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign csum_sum = csum_q + byte_data_i;
`endif

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    wcnt_d  = wcnt_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
    err_d   = err_q;
`endif
    case (state_q)
      IDLE, RUN: begin
        if (start_i) begin
          len_d  = clamp_len(len_words_i);
          wcnt_d = '0;
          bcnt_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d = '0;
          err_d  = 1'b0;
`endif
          if (len_d == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = CHECK;
`else
            state_d = RUN;
            done_d  = 1'b1;
`endif
          end else begin
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        if (hs) begin
          shift_d = shifted;
          bcnt_d  = bcnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d  = csum_sum;
`endif
          if (bcnt_q == 2'd3) begin
            state_d = WRITE;
            addr_d  = wcnt_q[ADDR_W-1:0];
            wdata_d = shifted;
          end
        end
      end
      WRITE: begin
        // The counter is one bit wider than the address so a full-depth image terminates cleanly.
        wcnt_d = wcnt_q + WCNT_ONE;
        if (wcnt_d == len_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = CHECK;
`else
          state_d = RUN;
          done_d  = 1'b1;
`endif
        end else begin
          state_d = LOAD;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: begin
        if (hs) begin
          if (csum_sum == 8'd0) begin
            state_d = RUN;
            done_d  = 1'b1;
          end else begin
            state_d = IDLE;
            err_d   = 1'b1;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with the state register.
    ready_d = (state_d == LOAD);
    busy_d  = (state_d == LOAD) || (state_d == WRITE);
`ifdef IMEM_LOADER_CHECKSUM_EN
    ready_d = ready_d || (state_d == CHECK);
    busy_d  = busy_d  || (state_d == CHECK);
`endif
    we_d    = (state_d == WRITE);
    run_d   = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      wcnt_q  <= '0;
      bcnt_q  <= '0;
      shift_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      wcnt_q  <= wcnt_d;
      bcnt_q  <= bcnt_d;
      shift_q <= shift_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      run_q   <= run_d;
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_q <= '0;
      err_q  <= 1'b0;
    end else begin
      csum_q <= csum_d;
      err_q  <= err_d;
    end
  end
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign byte_ready_o = ready_q;
  assign imem_we_o    = we_q;
  assign imem_addr_o  = addr_q;
  assign imem_wdata_o = wdata_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign core_run_o   = run_q;

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction-memory loader for the single-cycle `mips` core. It accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, and writes them into instruction memory from word address 0. Once loading finishes it releases the core by asserting `core_run`. It sits upstream of the core and its instruction memory, and replaces hard-coded memory init in system-level benches.

## Interface
- `ADDR_W`, 8: instruction-memory word-address width; maximum image is 2^ADDR_W words.
- `clk` in 1: rising-edge clock shared with the core.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle request to begin a load. Samples `len_words`.
- `len_words` in ADDR_W+1: number of 32-bit words to load, 0..2^ADDR_W. Values above 2^ADDR_W are clamped to 2^ADDR_W.
- `byte_valid` in 1: `byte_data` is valid.
- `byte_data` in 8: stream byte.
- `byte_ready` out 1: loader accepts a byte this cycle.
- `imem_we` out 1: instruction-memory write strobe.
- `imem_addr` out ADDR_W: word address for the write.
- `imem_wdata` out 32: instruction word to write.
- `busy` out 1: a load is in progress.
- `done` out 1: one-cycle pulse when a load completes successfully.
- `err` out 1: sticky error flag; cleared by the next accepted `start`.
- `core_run` out 1: high means the core may execute. Low holds the core.

## Operation
- The FSM has five states: IDLE, LOAD, WRITE, CHECK, RUN. CHECK exists only with `IMEM_LOADER_CHECKSUM_EN`.
- Reset: state is IDLE, and all outputs, the byte counter, word counter, shift register and checksum are 0.
- **IDLE.** When `start` is high, latch the clamped `len_words`, clear `err`, and zero the counters and checksum.
  - If the length is 0, go to CHECK when the checksum feature is built, otherwise to RUN.
  - If the length is nonzero, go to LOAD.
- **LOAD.** `byte_ready` is 1. Each handshake (`byte_valid && byte_ready`) shifts the byte into bits [7:0] of the word register after shifting left by 8, so the first byte ends in [31:24]. Each handshake increments the byte counter (mod 4) and adds the byte to the 8-bit checksum. On the 4th byte, go to WRITE.
- **WRITE.** Lasts one cycle.
  - `byte_ready` is 0 and `imem_we` is 1.
  - `imem_addr` is the word counter and `imem_wdata` is the assembled word.
  - The word counter increments. If it has reached the latched length, go to CHECK or RUN; otherwise return to LOAD.
- **CHECK.** `byte_ready` is 1. Accept one byte. If `(checksum + byte) mod 256 == 0`, go to RUN. Otherwise set `err` and go to IDLE.
- **RUN.** `core_run` is 1. A `start` here drops `core_run` in the same edge and begins a new load, exactly as from IDLE.
- `busy` is 1 in LOAD, WRITE and CHECK.
- `done` pulses on the cycle of entry into RUN.
- `start` is ignored while `busy` is 1.
- Full-depth image: the word counter is ADDR_W+1 bits wide, so `imem_addr` wraps only after the final write, and that wrap is never used.

## Timing
- All outputs are registered, and all state changes happen on the rising `clk` edge.
- A byte is consumed on the edge where `byte_valid` and `byte_ready` are both high. `byte_data` must be stable on that edge. `byte_valid` may stay high across the WRITE bubble, and that byte is accepted on the first LOAD cycle after it.
- With `byte_valid` held high continuously, each word costs 5 cycles: 4 accept cycles plus 1 write cycle.
- `core_run` rises 1 cycle after the last WRITE, or 1 cycle after the accepted checksum byte.
- Asserting `rst_n` low at any time, including mid-word or mid-write, immediately forces every output to 0. Partially written memory is not cleaned up.
- `err` and a mismatch take effect on the same edge as the checksum byte; `done` does not pulse in that case.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined: the CHECK state is present. After the last word the loader expects one trailer byte that makes the 8-bit sum of all bytes equal 0. A mismatch sets `err` and leaves `core_run` low.
- `IMEM_LOADER_CHECKSUM_EN` undefined: no CHECK state and no checksum logic. The loader goes straight from the last WRITE to RUN, and `err` is tied to 0.

## Test plan
- **Single word.** Reset, then `start` with `len_words`=1 and bytes 0x20,0x08,0x00,0x05 (plus trailer 0xD3 when the checksum is enabled) → one write of `imem_addr`=0, `imem_wdata`=0x20080005; `done` pulses; `core_run`=1.
- **Back-to-back.** `len_words`=3 with `byte_valid` held high → writes at addresses 0, 1, 2 on cycles 5, 10, 15 after the first accept; `byte_ready`=0 exactly on those cycles.
- **Throttled source.** `byte_valid` toggles every other cycle → identical words and addresses; no byte lost or duplicated.
- **Bad checksum (checksum built).** `len_words`=1, bytes 0x00,0x00,0x00,0x01, trailer 0x00 → `err`=1, `core_run`=0, state IDLE; a following good load clears `err`.
- **Reset mid-load.** Drop `rst_n` after 2 bytes of word 1 → all outputs 0 asynchronously; after release, a fresh `start` loads from address 0.
- **Corner cases.** `len_words`=0 → `core_run`=1 with no writes (after a 0x00 trailer when the checksum is built). `start` during LOAD is ignored. `start` in RUN drops `core_run` and reloads.
